// File: rtl/word_packer_n.sv
// word_packer_n: gathers RATIO narrow beats of IN_W bits into one IN_W*RATIO-bit word.
// Partial words can be flushed out with a lane-keep mask. Both sides use ready/valid
// handshakes, and everything runs on the rising edge of clk_4f.
module word_packer_n #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [IN_W-1:0]       data_in,
    output logic                  ready_in,
    input  logic                  flush,
    output logic                  valid_out,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      keep_out,
    input  logic                  ready_out
);

    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned CNT_W = $clog2(RATIO);

    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid_out;
    logic [OUT_W-1:0] r_data_out;
    logic [RATIO-1:0] r_keep_out;

    logic             w_slot_free;
    logic             w_last;
    logic             w_accept;
    logic             w_flush;
    logic             w_emit;
    int               w_lane;
    int               w_fill;
    logic [OUT_W-1:0] w_acc_next;
    logic [RATIO-1:0] w_keep_next;

    assign w_slot_free = !r_valid_out || ready_out;
    assign w_last      = (r_cnt == CNT_W'(RATIO - 1));
    // A beat that completes a word needs a free output slot. Earlier beats only
    // need the accumulator, unless a flush wants the slot first.
    assign ready_in    = !reset && (w_slot_free || (!w_last && !flush));
    assign w_accept    = valid_in && ready_in;
    assign w_flush     = flush && w_slot_free && !reset;
    assign w_emit      = (w_accept && w_last) || (w_flush && ((r_cnt != '0) || w_accept));

    // Work out which lane takes this beat, the accumulator with that beat folded in,
    // and the keep mask for the lanes filled so far.
    always_comb begin
        w_lane      = MSB_FIRST != 0 ? int'(RATIO - 1) - int'(r_cnt) : int'(r_cnt);
        w_acc_next  = r_acc;
        if (w_accept) begin
            w_acc_next[w_lane*IN_W +: IN_W] = data_in;
        end
        w_fill      = int'(r_cnt) + (w_accept ? 1 : 0);
        w_keep_next = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (k < w_fill) begin
                w_keep_next[MSB_FIRST != 0 ? int'(RATIO) - 1 - k : k] = 1'b1;
            end
        end
    end

    // Accumulator, lane count and output slot. An emission overwrites the slot
    // in the same cycle that its previous word drains.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
        end else if (w_emit) begin
            r_data_out  <= w_acc_next;
            r_keep_out  <= w_keep_next;
            r_valid_out <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_valid_out && ready_out) begin
                r_valid_out <= 1'b0;
            end
            if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;

endmodule

// File: tb/tb_word_packer_n.sv
// Bench for word_packer_n. It drives both lane orders from the same stimulus.
// A queue-based model predicts every output on each cycle, and literal checks
// pin down the words that are worked out by hand.
module tb_word_packer_n;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned OUT_W = IN_W * RATIO;

    logic             clk;
    logic             reset;
    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             flush;
    logic             ready_out;

    logic             rin1, vo1, rin0, vo0;
    logic [OUT_W-1:0] do1, do0;
    logic [RATIO-1:0] ko1, ko0;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    // Model state: beats waiting in arrival order, plus the predicted output slot.
    logic [IN_W-1:0]  m_q[$];
    logic             m_valid = 0;
    logic [OUT_W-1:0] m_data1 = '0, m_data0 = '0;
    logic [RATIO-1:0] m_keep1 = '0, m_keep0 = '0;

    word_packer_n #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) u_msb (
        .clk_4f(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(rin1), .flush(flush), .valid_out(vo1), .data_out(do1),
        .keep_out(ko1), .ready_out(ready_out)
    );

    word_packer_n #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) u_lsb (
        .clk_4f(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(rin0), .flush(flush), .valid_out(vo0), .data_out(do0),
        .keep_out(ko0), .ready_out(ready_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic model_ready();
        logic free;
        free = !m_valid || ready_out;
        return !reset && (free || ((m_q.size() < RATIO - 1) && !flush));
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        logic acc, fl, free;
        if (reset) begin
            m_q.delete();
            m_valid = 0;
            m_data1 = '0; m_data0 = '0; m_keep1 = '0; m_keep0 = '0;
        end else begin
            free = !m_valid || ready_out;
            acc  = valid_in && model_ready();
            fl   = flush && free;
            if (acc) m_q.push_back(data_in);
            if (m_q.size() == RATIO || (fl && m_q.size() > 0)) begin
                m_data1 = '0; m_data0 = '0; m_keep1 = '0; m_keep0 = '0;
                for (int k = 0; k < m_q.size(); k++) begin
                    m_data1[(RATIO - 1 - k) * IN_W +: IN_W] = m_q[k];
                    m_keep1[RATIO - 1 - k] = 1'b1;
                    m_data0[k * IN_W +: IN_W] = m_q[k];
                    m_keep0[k] = 1'b1;
                end
                m_valid = 1;
                m_q.delete();
            end else if (m_valid && ready_out) begin
                m_valid = 0;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_in_msb", 64'(rin1), 64'(model_ready()));
            chk("ready_in_lsb", 64'(rin0), 64'(model_ready()));
            chk("valid_out_msb", 64'(vo1), 64'(m_valid));
            chk("valid_out_lsb", 64'(vo0), 64'(m_valid));
            chk("data_out_msb", 64'(do1), 64'(m_data1));
            chk("data_out_lsb", 64'(do0), 64'(m_data0));
            chk("keep_out_msb", 64'(ko1), 64'(m_keep1));
            chk("keep_out_lsb", 64'(ko0), 64'(m_keep0));
        end
    end

    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic f, input logic ro);
        valid_in = v; data_in = d; flush = f; ready_out = ro;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; valid_in = 0; data_in = '0; flush = 0; ready_out = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("reset_valid", 64'(vo1), 64'(0));
        chk("reset_data", 64'(do1), 64'(0));
        chk("reset_ready_in", 64'(rin1), 64'(0));
        reset = 0;

        // 1: a full word in both lane orders
        cyc(1, 8'hA1, 0, 1); cyc(1, 8'hB2, 0, 1); cyc(1, 8'hC3, 0, 1); cyc(1, 8'hD4, 0, 1);
        chk("t1_valid", 64'(vo1), 64'(1));
        chk("t1_data_msb", 64'(do1), 64'h0000_0000_A1B2_C3D4);
        chk("t1_data_lsb", 64'(do0), 64'h0000_0000_D4C3_B2A1);
        chk("t1_keep", 64'(ko1), 64'hF);
        cyc(0, 8'h00, 0, 1);
        chk("t1_single_pulse", 64'(vo1), 64'(0));

        // 2: flush of a partial word, then a new word starting in the top lane
        cyc(1, 8'h11, 0, 1); cyc(1, 8'h22, 0, 1); cyc(0, 8'h00, 1, 1);
        chk("t2_data_msb", 64'(do1), 64'h0000_0000_1122_0000);
        chk("t2_keep_msb", 64'(ko1), 64'hC);
        chk("t2_data_lsb", 64'(do0), 64'h0000_0000_0000_2211);
        chk("t2_keep_lsb", 64'(ko0), 64'h3);
        cyc(1, 8'h33, 0, 1); cyc(0, 8'h00, 1, 1);
        chk("t2_new_word", 64'(do1), 64'h0000_0000_3300_0000);
        chk("t2_new_keep", 64'(ko1), 64'h8);

        // 3: the last beat arrives together with flush, then a flush with nothing held
        cyc(1, 8'h01, 0, 1); cyc(1, 8'h02, 0, 1); cyc(1, 8'h03, 0, 1); cyc(1, 8'h04, 1, 1);
        chk("t3_data", 64'(do1), 64'h0000_0000_0102_0304);
        chk("t3_keep", 64'(ko1), 64'hF);
        cyc(0, 8'h00, 0, 1);
        chk("t3_one_word", 64'(vo1), 64'(0));
        cyc(0, 8'h00, 1, 1);
        chk("t3_empty_flush", 64'(vo1), 64'(0));

        // 4: gaps between beats must not lose data
        cyc(1, 8'h10, 0, 1); repeat (3) cyc(0, 8'hFF, 0, 1);
        cyc(1, 8'h20, 0, 1); repeat (3) cyc(0, 8'hFF, 0, 1);
        cyc(1, 8'h30, 0, 1); repeat (3) cyc(0, 8'hFF, 0, 1);
        cyc(1, 8'h40, 0, 1);
        chk("t4_data_msb", 64'(do1), 64'h0000_0000_1020_3040);
        chk("t4_data_lsb", 64'(do0), 64'h0000_0000_4030_2010);

        // 5: backpressure on the output side
        cyc(1, 8'h51, 0, 1); cyc(1, 8'h52, 0, 1); cyc(1, 8'h53, 0, 1); cyc(1, 8'h54, 0, 1);
        cyc(1, 8'h61, 0, 0); cyc(1, 8'h62, 0, 0); cyc(1, 8'h63, 0, 0);
        valid_in = 1; data_in = 8'h64; flush = 0; ready_out = 0;
        #1;
        chk("t5_ready_low", 64'(rin1), 64'(0));
        @(posedge clk); #1;
        chk("t5_hold_data", 64'(do1), 64'h0000_0000_5152_5354);
        chk("t5_hold_valid", 64'(vo1), 64'(1));
        ready_out = 1;
        #1;
        chk("t5_ready_back", 64'(rin1), 64'(1));
        @(posedge clk); #1;
        chk("t5_word2", 64'(do1), 64'h0000_0000_6162_6364);
        cyc(0, 8'h00, 0, 1);

        // 6: reset mid-word while a word is still pending on the output
        cyc(1, 8'h81, 0, 1); cyc(1, 8'h82, 0, 1); cyc(1, 8'h83, 0, 1); cyc(1, 8'h84, 0, 1);
        cyc(1, 8'h91, 0, 0); cyc(1, 8'h92, 0, 0);
        reset = 1;
        cyc(1, 8'hEE, 1, 0);
        chk("t6_valid", 64'(vo1), 64'(0));
        chk("t6_data", 64'(do1), 64'(0));
        chk("t6_keep", 64'(ko1), 64'(0));
        reset = 0;
        cyc(1, 8'h0A, 0, 1); cyc(1, 8'h0B, 0, 1); cyc(1, 8'h0C, 0, 1); cyc(1, 8'h0D, 0, 1);
        chk("t6_data_new", 64'(do1), 64'h0000_0000_0A0B_0C0D);
        chk("t6_keep_new", 64'(ko1), 64'hF);

        // Mixed directed pattern, checked only by the model
        for (int i = 0; i < 40; i++) begin
            cyc(logic'((i % 4) != 2), 8'(i * 7 + 3), logic'((i % 5) == 4),
                logic'((i % 3) != 0));
        end
        cyc(0, 8'h00, 0, 1);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/word_packer_n.md
# word_packer_n

Parametrised serial-to-parallel word packer that gathers `RATIO` narrow beats of `IN_W` bits into one `IN_W*RATIO`-bit word. It is the generalised successor to the fixed 8-to-32-bit packer on the `clk_4f` domain. Beyond the fixed packer it adds:
- configurable width, ratio and lane order;
- accumulation that survives gaps in `valid_in`;
- a flush that emits partial words with a lane-keep mask;
- ready/valid backpressure on both sides.

It sits between the byte-stream source and the word-wide consumer on the `clk_4f` domain.

## Interface
Parameters:
- `IN_W`, default 8: input beat width in bits; must be ≥1.
- `RATIO`, default 4: beats per output word; must be ≥2, not required to be a power of two. `OUT_W = IN_W*RATIO`.
- `MSB_FIRST`, default 1: 1 places the first beat in the top lane `data_out[OUT_W-1 -: IN_W]`; 0 places it in the bottom lane `[IN_W-1:0]`.

Ports:
- `clk_4f`  in  1  sole clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  an input beat is present.
- `data_in`  in  IN_W  beat data.
- `ready_in`  out  1  the packer accepts a beat this cycle (combinational).
- `flush`  in  1  request to emit the current partial word.
- `valid_out`  out  1  `data_out`/`keep_out` hold a word.
- `data_out`  out  OUT_W  packed word.
- `keep_out`  out  RATIO  per-lane valid mask; bit i covers `data_out[i*IN_W +: IN_W]`.
- `ready_out`  in  1  the consumer takes the word this cycle.

## Operation
Internal state:
- lane accumulator, `OUT_W` bits;
- lane count `cnt`, `$clog2(RATIO)` bits, range 0..RATIO-1;
- one output register slot (`valid_out`, `data_out`, `keep_out`).

Handshake rules:
- **Output slot free:** `S = !valid_out || ready_out`.
- **ready_in:** `ready_in = !reset && (S || (cnt < RATIO-1 && !flush))`. Beats that do not complete a word are accepted even while the output is stalled.
- **Beat accepted:** `A = valid_in && ready_in`. On accept, `data_in` is written into lane `cnt`, counted in arrival order.
- **Flush taken:** `F = flush && S && !reset`. A flush not taken is ignored; the source holds `flush` until it is taken.

Lane mapping:
- With `MSB_FIRST=1`, arrival k goes to lane RATIO-1-k.
- With `MSB_FIRST=0`, arrival k goes to lane k.

Emission occurs when `E = (A && cnt==RATIO-1) || (F && (cnt>0 || A))`. On the emission edge:
- the output register loads the accumulator, including the beat accepted this cycle;
- unfilled lanes are loaded as zero;
- `keep_out` has one bit set per filled lane, at the positions given by `MSB_FIRST`;
- `valid_out` is set to 1;
- the accumulator and `cnt` are cleared to 0.

Other cases:
- **Beat and flush together:** the beat is packed first, then the word is emitted. If that beat is the RATIO-th, the word is full and `keep_out` is all ones.
- **Flush with `cnt==0` and no beat:** no-op; nothing is emitted.
- **Valid gaps:** `valid_in=0` cycles leave the accumulator and `cnt` unchanged. Partial data is never discarded except by reset.
- **No emission:** if `valid_out && ready_out`, then `valid_out` falls to 0. Otherwise the output register holds.
- **Output stability:** `data_out` and `keep_out` are stable while `valid_out && !ready_out`.
- **Arithmetic:** `cnt` increments by 1 per accepted non-emitting beat. `cnt` never reaches RATIO, because it is cleared on emission.

Reset (any cycle, including mid-word or with a pending output) forces, on that edge:
- `cnt = 0` and accumulator = 0;
- `valid_out = 0`, `data_out = 0`, `keep_out = 0`.

While `reset=1`, `ready_in = 0`, beats are ignored, and `flush` is ignored.

## Timing
- **Latency:** the word completes on the edge that accepts the RATIO-th beat (edge N), and `valid_out=1` is visible from edge N onward. This is one cycle of latency from the last beat.
- **Throughput:** one word per RATIO cycles with continuous `valid_in` and `ready_out=1`. There are no bubbles, because emission and draining overlap in the same cycle.
- **Stall:** when the output is stalled and `cnt==RATIO-1`, `ready_in` drops to 0. It returns to 1 in the same cycle that `ready_out` is 1.
- **Combinational paths:** the only combinational path is `ready_out`/`flush` to `ready_in`. There is no combinational path from input to `data_out`.

## Test plan
All scenarios use IN_W=8, RATIO=4 and `ready_out=1` unless stated otherwise.

1. Reset, then beats 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles, MSB_FIRST=1 -> one `valid_out` pulse after the 4th edge with `data_out=0xA1B2C3D4`, `keep_out=4'b1111`. Repeat with MSB_FIRST=0 -> `data_out=0xD4C3B2A1`.
2. Beats 0x11 and 0x22, then `flush` alone -> `data_out=0x11220000`, `keep_out=4'b1100`. A following 0x33 starts a new word in lane 3.
3. Beats 0x01, 0x02, 0x03, then 0x04 together with `flush` -> `data_out=0x01020304`, `keep_out=4'b1111`, one word only. A flush with `cnt=0` and no beat -> no `valid_out`.
4. Beats 0x10, 0x20, 0x30 with 3 idle cycles between each, then 0x40 -> `data_out=0x10203040`, showing no loss across gaps.
5. Backpressure: emit word 1, hold `ready_out=0`, send 4 more beats -> the first 3 are accepted and `ready_in` falls to 0 on the 4th; `data_out` holds word 1. Raise `ready_out` -> the 4th beat is accepted that cycle and word 2 appears on the next edge.
6. Reset asserted after 2 beats, with a word pending on the output -> `valid_out=0`, `data_out=0`, `keep_out=0` after that edge. Four new beats 0x0A–0x0D -> `data_out=0x0A0B0C0D`, with no stale lanes.
